fast_frame_ctrl: RTL and testbench

- Frame-level sequencer for the 7x7 FAST corner-score datapath.
- Accepts a raster pixel stream with a valid/ready handshake and advances the line buffers and window (`win_shift`).
- Tracks row and column position and marks which shifts complete an interior window.
- Aligns the datapath's fixed latency, buffers scores in a credit-protected output FIFO, and emits a dense score map with centre coordinates and frame start/done control.

---
 rtl/fast_frame_ctrl.sv | 164 ++++++++++++++++
 tb/tb_fast_frame_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fast_frame_ctrl.sv
// rtl/fast_frame_ctrl.sv - frame sequencer for the 7x7 FAST corner-score datapath
// Raster counters, latency-aligned window tagging and a credit-protected score FIFO.
module fast_frame_ctrl #(
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480,
  parameter int KERNEL_SIZE = 7,
  parameter int SCORE_W     = 13,
  parameter int DP_LAT      = 2,
  parameter int OUT_DEPTH   = 4,
  parameter int COORD_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  input  logic               s_valid,
  output logic               s_ready,
  output logic               win_shift,
  input  logic [SCORE_W-1:0] dp_score,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [SCORE_W-1:0] m_score,
  output logic [COORD_W-1:0] m_x,
  output logic [COORD_W-1:0] m_y,
  output logic               m_last
);

  localparam int HALF  = KERNEL_SIZE / 2;
  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CNT_W = $clog2(OUT_DEPTH + 1);
  localparam int INF_W = $clog2(DP_LAT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [COORD_W-1:0] col, row;
  logic [DP_LAT-1:0]  pipe_v, pipe_l;
  logic [COORD_W-1:0] pipe_x [DP_LAT];
  logic [COORD_W-1:0] pipe_y [DP_LAT];

  logic [SCORE_W-1:0] mem_score [OUT_DEPTH];
  logic [COORD_W-1:0] mem_x [OUT_DEPTH];
  logic [COORD_W-1:0] mem_y [OUT_DEPTH];
  logic [OUT_DEPTH-1:0] mem_last;
  logic [PTR_W-1:0]   wptr, rptr;
  logic [CNT_W-1:0]   fifo_count;
  logic [INF_W-1:0]   inflight;

  logic col_end, row_end, last_pix, interior, push, pop, frame_start, drain_exit;

  assign col_end     = (col == COORD_W'(IMG_WIDTH - 1));
  assign row_end     = (row == COORD_W'(IMG_HEIGHT - 1));
  assign last_pix    = col_end & row_end;
  assign interior    = (row >= COORD_W'(KERNEL_SIZE - 1)) & (col >= COORD_W'(KERNEL_SIZE - 1));
  assign frame_start = (state == IDLE) & start & ~abort;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < DP_LAT; i++) inflight = inflight + INF_W'(pipe_v[i]);
  end

  // Credits cover every interior window already accepted but not yet popped.
  assign s_ready   = (state == RUN) && ((32'(fifo_count) + 32'(inflight)) < 32'(OUT_DEPTH));
  assign win_shift = s_valid & s_ready;

  assign push    = pipe_v[DP_LAT-1];
  assign m_valid = (fifo_count != '0);
  assign pop     = m_valid & m_ready;
  assign m_score = m_valid ? mem_score[rptr] : '0;
  assign m_x     = m_valid ? mem_x[rptr] : '0;
  assign m_y     = m_valid ? mem_y[rptr] : '0;
  assign m_last  = m_valid & mem_last[rptr];
  assign busy    = (state == RUN) | (state == DRAIN);
  assign done    = (state == DONE);

  // The last window is the final one produced, so popping it as the sole entry ends the frame.
  assign drain_exit = pop & m_last & (fifo_count == CNT_W'(1)) & (inflight == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (win_shift && last_pix) state_nxt = DRAIN;
      DRAIN:   if (drain_exit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (frame_start) begin
      col <= '0;
      row <= '0;
    end else if (win_shift) begin
      if (col_end) begin
        col <= '0;
        if (!row_end) row <= row + COORD_W'(1);
      end else begin
        col <= col + COORD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v <= '0;
    end else if (abort) begin
      pipe_v <= '0;
    end else begin
      pipe_v[0] <= win_shift & interior;
      for (int i = 1; i < DP_LAT; i++) pipe_v[i] <= pipe_v[i-1];
    end
  end

  always_ff @(posedge clk) begin
    pipe_x[0] <= col - COORD_W'(HALF);
    pipe_y[0] <= row - COORD_W'(HALF);
    pipe_l[0] <= last_pix;
    for (int i = 1; i < DP_LAT; i++) begin
      pipe_x[i] <= pipe_x[i-1];
      pipe_y[i] <= pipe_y[i-1];
      pipe_l[i] <= pipe_l[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
    end else if (abort) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wptr <= (wptr == PTR_W'(OUT_DEPTH - 1)) ? '0 : wptr + PTR_W'(1);
      if (pop)  rptr <= (rptr == PTR_W'(OUT_DEPTH - 1)) ? '0 : rptr + PTR_W'(1);
      if (push && !pop)      fifo_count <= fifo_count + CNT_W'(1);
      else if (!push && pop) fifo_count <= fifo_count - CNT_W'(1);
    end
  end

  // dp_score is sampled in the same cycle its window flag leaves the pipe.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_score[wptr] <= dp_score;
      mem_x[wptr]     <= pipe_x[DP_LAT-1];
      mem_y[wptr]     <= pipe_y[DP_LAT-1];
      mem_last[wptr]  <= pipe_l[DP_LAT-1];
    end
  end

endmodule

// File: tb/tb_fast_frame_ctrl.sv
// tb/tb_fast_frame_ctrl.sv - randomized directed bench for fast_frame_ctrl
// A behavioural datapath drives dp_score; expected outputs come from a raster-order window list.
`timescale 1ns/1ps
module tb_fast_frame_ctrl;
  localparam int W    = 10;
  localparam int H    = 8;
  localparam int SW   = 13;
  localparam int CW   = 16;
  localparam int DEP  = 4;
  localparam int PIX  = W * H;
  localparam int NEXP = (W - 6) * (H - 6);

  logic clk = 1'b0;
  logic rst_n, start, abort, s_valid, m_ready;
  logic busy, done, s_ready, win_shift, m_valid, m_last;
  logic [SW-1:0] dp_score = '0;
  logic [SW-1:0] m_score;
  logic [CW-1:0] m_x, m_y;

  int checks = 0;
  int errors = 0;
  int exp_x [NEXP];
  int exp_y [NEXP];
  int exp_s [NEXP];
  int exp_l [NEXP];
  int shift_cnt = 0;
  int d1 = -1;

  always #5 clk = ~clk;

  fast_frame_ctrl #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL_SIZE(7), .SCORE_W(SW),
    .DP_LAT(2), .OUT_DEPTH(DEP), .COORD_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy), .done(done),
    .s_valid(s_valid), .s_ready(s_ready), .win_shift(win_shift), .dp_score(dp_score),
    .m_valid(m_valid), .m_ready(m_ready), .m_score(m_score), .m_x(m_x), .m_y(m_y),
    .m_last(m_last)
  );

  function automatic logic [SW-1:0] score_of(input int idx);
    return (idx % 7 == 3) ? '0 : SW'(100 + idx);
  endfunction

  // Two-cycle datapath: a shift's score appears DP_LAT edges after the shift.
  always @(posedge clk) begin
    if (start && !busy && !abort) shift_cnt <= 0;
    else if (win_shift)           shift_cnt <= shift_cnt + 1;
    d1       <= win_shift ? shift_cnt : -1;
    dp_score <= (d1 >= 0) ? score_of(d1) : '0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_s_ready"}, 32'(s_ready), 0);
    chk({tag, "_m_valid"}, 32'(m_valid), 0);
    chk({tag, "_m_last"}, 32'(m_last), 0);
    chk({tag, "_m_score"}, 32'(m_score), 0);
    chk({tag, "_m_x"}, 32'(m_x), 0);
    chk({tag, "_m_y"}, 32'(m_y), 0);
  endtask

  // mode: 0 basic, 1 input bubbles, 2 output stall, 3 start during run, 4 abort, 5 reset in drain
  task automatic run_frame(input int mode);
    int k = 0, pix = 0, outstanding = 0, stall_left = 0;
    bit fin = 0, stalled = 0, have_prev = 0, last_hs = 0, saw_block = 0;
    logic [SW-1:0] prev_s;
    logic [CW-1:0] prev_x, prev_y;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      start   = (mode == 3 && pix == 20);
      s_valid = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      m_ready = 1'b1;
      if (mode == 2 && k == 2 && !stalled) begin stall_left = 20; stalled = 1; end
      if (stall_left > 0) begin m_ready = 1'b0; stall_left--; end
      if (mode == 5 && pix >= 75) m_ready = 1'b0;
      if (mode == 4 && pix == 40) begin
        abort = 1'b1; s_valid = 1'b0; m_ready = 1'b0; start = 1'b0;
        @(negedge clk); abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_m_valid", 32'(m_valid), 0);
        chk("abort_s_ready", 32'(s_ready), 0);
        repeat (5) begin chk("abort_no_done", 32'(done), 0); @(negedge clk); end
        fin = 1;
      end else if (mode == 5 && pix == PIX && m_valid) begin
        s_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        fin = 1;
      end else begin
        if (have_prev && m_valid) begin
          chk("stall_x_stable", 32'(m_x), 32'(prev_x));
          chk("stall_y_stable", 32'(m_y), 32'(prev_y));
          chk("stall_score_stable", 32'(m_score), 32'(prev_s));
        end
        chk("s_ready_credit", 32'(s_ready), 32'((pix < PIX) && (outstanding < DEP)));
        if (!s_ready && pix < PIX) saw_block = 1;
        have_prev = m_valid && !m_ready;
        prev_x = m_x; prev_y = m_y; prev_s = m_score;
        if (m_valid && m_ready) begin
          if (k < NEXP) begin
            chk("out_x", 32'(m_x), 32'(exp_x[k]));
            chk("out_y", 32'(m_y), 32'(exp_y[k]));
            chk("out_score", 32'(m_score), 32'(exp_s[k]));
            chk("out_last", 32'(m_last), 32'(exp_l[k]));
          end else begin
            chk("extra_output", 32'(k), NEXP - 1);
          end
          if (m_last) last_hs = 1;
          k++;
          outstanding--;
        end
        if (s_valid && s_ready) begin
          if (pix / W >= 6 && pix % W >= 6) outstanding++;
          pix++;
        end
        @(negedge clk);
        if (last_hs) begin
          s_valid = 1'b0; m_ready = 1'b0;
          chk("done_pulse", 32'(done), 1);
          chk("busy_in_done", 32'(busy), 0);
          @(negedge clk);
          chk("done_cleared", 32'(done), 0);
          chk("busy_after_frame", 32'(busy), 0);
          fin = 1;
        end
      end
    end
    s_valid = 1'b0; m_ready = 1'b0; start = 1'b0;
    chk("frame_finished", 32'(fin), 1);
    if (mode < 4) chk("output_count", 32'(k), NEXP);
    if (mode == 2) chk("s_ready_dropped", 32'(saw_block), 1);
  endtask

  initial begin
    int n = 0;
    for (int r = 6; r < H; r++)
      for (int c = 6; c < W; c++) begin
        exp_x[n] = c - 3;
        exp_y[n] = r - 3;
        exp_s[n] = int'(score_of(r * W + c));
        exp_l[n] = (r == H - 1 && c == W - 1) ? 1 : 0;
        n++;
      end
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(0);
    run_frame(1);
    run_frame(2);
    run_frame(3);
    run_frame(4);
    run_frame(0);
    run_frame(5);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_busy", 32'(busy), 0);
    chk("post_reset_m_valid", 32'(m_valid), 0);
    chk("post_reset_s_ready", 32'(s_ready), 0);
    run_frame(0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
